// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples SCLK/LRCLK/SDIN in the clk domain and
// delivers left-justified stereo frames over a valid/ready handshake.
module i2s_rx #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_sclk,
    input  logic             i_lrclk,
    input  logic             i_sdin,
    input  logic             i_ready,
    input  logic             i_clr_ovr,
    output logic [WIDTH-1:0] o_left,
    output logic [WIDTH-1:0] o_right,
    output logic             o_valid,
    output logic             o_overrun,
    output logic             o_sync
);

    typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

    logic [2:0]       sclk_q;
    logic [1:0]       ws_sync_q, sd_sync_q;
    logic             ws_prev_q, ws_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d, shift_ins;
    logic [WIDTH-1:0] word_q, word_d;
    logic             word_ch_q, word_ch_d;
    logic             word_done_q, word_done_d;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] left_hold_q, left_hold_d;
    logic [WIDTH-1:0] left_q, left_d, right_q, right_d;
    logic             valid_q, valid_d, ovr_q, ovr_d;
    logic             bit_edge, ws, sd, emit;

    assign bit_edge = sclk_q[1] & ~sclk_q[2];
    assign ws       = ws_sync_q[1];
    assign sd       = sd_sync_q[1];

    // Bit capture; a ws change marks the last bit of the previous channel's word.
    always_comb begin
        shift_ins   = shift_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CNT_W'(WIDTH - 1 - i)) shift_ins[i] = sd;
        end
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        ws_prev_d   = ws_prev_q;
        word_d      = word_q;
        word_ch_d   = word_ch_q;
        word_done_d = 1'b0;
        if (bit_edge) begin
            ws_prev_d = ws;
            if (ws != ws_prev_q) begin
                word_d      = shift_ins;
                word_ch_d   = ws_prev_q;
                word_done_d = 1'b1;
                shift_d     = '0;
                cnt_d       = '0;
            end else begin
                shift_d = shift_ins;
                cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        left_hold_d = left_hold_q;
        emit        = 1'b0;
        case (state_q)
            HUNT:  if (word_done_q && word_ch_q) state_d = LEFT;
            LEFT:  if (word_done_q && !word_ch_q) begin
                       left_hold_d = word_q;
                       state_d     = RIGHT;
                   end
            RIGHT: if (word_done_q && word_ch_q) begin
                       emit    = 1'b1;
                       state_d = LEFT;
                   end
            default: state_d = HUNT;
        endcase
    end

    // A new frame replaces the held one only if the held one is consumed this clk.
    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (valid_q && i_ready) valid_d = 1'b0;
        if (i_clr_ovr) ovr_d = 1'b0;
        if (emit) begin
            if (!valid_q || i_ready) begin
                left_d  = left_hold_q;
                right_d = word_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_q      <= '0;
            ws_sync_q   <= '0;
            sd_sync_q   <= '0;
            ws_prev_q   <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            word_q      <= '0;
            word_ch_q   <= 1'b0;
            word_done_q <= 1'b0;
            state_q     <= HUNT;
            left_hold_q <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[1:0], i_sclk};
            ws_sync_q   <= {ws_sync_q[0], i_lrclk};
            sd_sync_q   <= {sd_sync_q[0], i_sdin};
            ws_prev_q   <= ws_prev_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            word_q      <= word_d;
            word_ch_q   <= word_ch_d;
            word_done_q <= word_done_d;
            state_q     <= state_d;
            left_hold_q <= left_hold_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
        end
    end

    assign o_left    = left_q;
    assign o_right   = right_q;
    assign o_valid   = valid_q;
    assign o_overrun = ovr_q;
    assign o_sync    = (state_q != HUNT);

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: vector table of slot widths plus hand-written
// backpressure, reset and alignment sequences.
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_sclk = 1'b0, i_lrclk = 1'b0, i_sdin = 1'b0;
    logic        i_ready = 1'b1, i_clr_ovr = 1'b0;
    logic [15:0] o_left, o_right;
    logic        o_valid, o_overrun, o_sync;

    int          checks = 0, errors = 0;
    int          hs_cnt = 0, hs_base;
    logic [15:0] cap_l = '0, cap_r = '0;
    int          lat = -1;

    typedef struct {
        int          n;
        logic [31:0] l, r;
        logic [15:0] el, er;
    } vec_t;
    vec_t vecs[5];

    i2s_rx #(.WIDTH(16), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .i_sclk(i_sclk), .i_lrclk(i_lrclk),
        .i_sdin(i_sdin), .i_ready(i_ready), .i_clr_ovr(i_clr_ovr),
        .o_left(o_left), .o_right(o_right), .o_valid(o_valid),
        .o_overrun(o_overrun), .o_sync(o_sync)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so a handshake seen here is the one the DUT takes.
    always @(negedge clk) begin
        if (o_valid && i_ready) begin
            hs_cnt++;
            cap_l = o_left;
            cap_r = o_right;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("check %s ok: %h", name, act);
        end
    endtask

    task automatic send_bit(input logic ws, input logic sd, input bit meas);
        tick();
        i_lrclk = ws;
        i_sdin  = sd;
        repeat (15) tick();
        i_sclk = 1'b1;
        if (meas) begin
            lat = -1;
            for (int j = 1; j <= 20; j++) begin
                tick();
                if (o_valid) begin
                    lat = j;
                    break;
                end
            end
        end
        repeat (16) tick();
        i_sclk = 1'b0;
    endtask

    // ws leads data by one bit: each bit carries the ws of the bit after it.
    task automatic send_bits(input int n, input logic [31:0] l, input logic [31:0] r,
                             input int ks, input int ke, input bit meas);
        logic sd, ws;
        for (int k = ks; k <= ke; k++) begin
            sd = (k < n) ? l[n-1-k] : r[2*n-1-k];
            ws = (k + 1 < n) ? 1'b0 : ((k + 1 < 2*n) ? 1'b1 : 1'b0);
            send_bit(ws, sd, meas && (k == 2*n-1));
        end
    endtask

    task automatic send_frame(input int n, input logic [31:0] l, input logic [31:0] r,
                              input bit meas);
        send_bits(n, l, r, 0, 2*n-1, meas);
    endtask

    initial begin
        vecs[0] = '{16, 32'h1234,   32'hABCD,   16'h1234, 16'hABCD};
        vecs[1] = '{24, 32'h123456, 32'hFEDCBA, 16'h1234, 16'hFEDC};
        vecs[2] = '{8,  32'hA5,     32'h3C,     16'hA500, 16'h3C00};
        vecs[3] = '{16, 32'h0000,   32'hFFFF,   16'h0000, 16'hFFFF};
        vecs[4] = '{2,  32'h3,      32'h1,      16'hC000, 16'h4000};

        repeat (3) tick();
        chk("rst_left",  32'(o_left), 0);
        chk("rst_right", 32'(o_right), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_ovr",   32'(o_overrun), 0);
        chk("rst_sync",  32'(o_sync), 0);
        reset = 1'b1;
        repeat (3) tick();

        // Alignment frame: consumed by HUNT, nothing emitted
        hs_base = hs_cnt;
        send_frame(16, 32'h9999, 32'h8888, 1'b0);
        chk("hunt_no_emit", 32'(hs_cnt - hs_base), 0);
        chk("hunt_sync",    32'(o_sync), 1);

        for (int i = 0; i < 5; i++) begin
            hs_base = hs_cnt;
            send_frame(vecs[i].n, vecs[i].l, vecs[i].r, i == 0);
            chk($sformatf("vec%0d_count", i), 32'(hs_cnt - hs_base), 1);
            chk($sformatf("vec%0d_left", i),  32'(cap_l), 32'(vecs[i].el));
            chk($sformatf("vec%0d_right", i), 32'(cap_r), 32'(vecs[i].er));
            chk($sformatf("vec%0d_ovr", i),   32'(o_overrun), 0);
            if (i == 0) chk("latency_4_5", 32'(lat >= 4 && lat <= 5), 1);
        end

        // Backpressure: second frame dropped, held frame unchanged
        i_ready = 1'b0;
        send_frame(16, 32'h1111, 32'h2222, 1'b0);
        chk("bp_valid", 32'(o_valid), 1);
        chk("bp_left1", 32'(o_left), 32'h1111);
        send_frame(16, 32'h3333, 32'h4444, 1'b0);
        chk("bp_hold_left",  32'(o_left), 32'h1111);
        chk("bp_hold_right", 32'(o_right), 32'h2222);
        chk("bp_ovr",        32'(o_overrun), 1);
        chk("bp_valid2",     32'(o_valid), 1);
        hs_base = hs_cnt;
        i_ready = 1'b1;
        tick();
        tick();
        chk("bp_drain_count", 32'(hs_cnt - hs_base), 1);
        chk("bp_drain_left",  32'(cap_l), 32'h1111);
        chk("bp_drain_valid", 32'(o_valid), 0);
        send_frame(16, 32'h5555, 32'h6666, 1'b0);
        chk("bp_next_left",  32'(cap_l), 32'h5555);
        chk("bp_next_right", 32'(cap_r), 32'h6666);
        chk("bp_ovr_sticky", 32'(o_overrun), 1);
        i_clr_ovr = 1'b1;
        tick();
        i_clr_ovr = 1'b0;
        tick();
        chk("clr_ovr", 32'(o_overrun), 0);

        // Reset mid-frame during left bit 7
        i_ready = 1'b0;
        send_frame(16, 32'h0F0F, 32'hF0F0, 1'b0);
        chk("mid_pre_left", 32'(o_left), 32'h0F0F);
        send_bits(16, 32'h5A5A, 32'hA5A5, 0, 7, 1'b0);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_left",  32'(o_left), 0);
        chk("mid_rst_right", 32'(o_right), 0);
        chk("mid_rst_valid", 32'(o_valid), 0);
        chk("mid_rst_sync",  32'(o_sync), 0);
        tick();
        reset = 1'b1;
        i_ready = 1'b1;
        hs_base = hs_cnt;
        send_bits(16, 32'h5A5A, 32'hA5A5, 8, 31, 1'b0);
        chk("mid_partial_none", 32'(hs_cnt - hs_base), 0);
        chk("mid_resync",       32'(o_sync), 1);
        send_frame(16, 32'h7777, 32'h8888, 1'b0);
        chk("mid_first_count", 32'(hs_cnt - hs_base), 1);
        chk("mid_first_left",  32'(cap_l), 32'h7777);
        chk("mid_first_right", 32'(cap_r), 32'h8888);

        // Startup alignment: release reset mid right slot
        reset = 1'b0;
        for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        hs_base = hs_cnt;
        for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b1, 1'b0);
        chk("start_sync_low", 32'(o_sync), 0);
        send_bit(1'b0, 1'b1, 1'b0);
        chk("start_sync_high", 32'(o_sync), 1);
        chk("start_no_partial", 32'(hs_cnt - hs_base), 0);
        send_frame(16, 32'hC0DE, 32'hBEEF, 1'b0);
        chk("start_count", 32'(hs_cnt - hs_base), 1);
        chk("start_left",  32'(cap_l), 32'hC0DE);
        chk("start_right", 32'(cap_r), 32'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver (slave): recovers left/right PCM words from an external I2S stream (SCLK, LRCLK, SDIN driven by an ADC or another board).
- Counterpart of the i2s transmitter feeding the PMOD DAC; gives the design an audio input path, e.g. for sampling or loopback test of the sound output.
- Oversamples all I2S lines in the system clk domain; no logic is clocked by SCLK.
- Delivers complete stereo frames over a valid/ready handshake.

Parameters:
- WIDTH, 16, bits per channel word presented on o_left/o_right.
- CNT_W, 6, bit-counter width; slots up to 2^CNT_W-1 bits.

Ports:
- clk  input  1  system clock (100 MHz); must be >= 4x SCLK frequency.
- reset  input  1  asynchronous, active-low reset.
- i_sclk  input  1  I2S bit clock, asynchronous to clk.
- i_lrclk  input  1  I2S word select; 0 = left, 1 = right.
- i_sdin  input  1  I2S serial data, MSB first.
- i_ready  input  1  consumer accepts frame when high with o_valid.
- i_clr_ovr  input  1  synchronous clear of o_overrun.
- o_left  output  WIDTH  left sample of held frame.
- o_right  output  WIDTH  right sample of held frame.
- o_valid  output  1  frame held and available.
- o_overrun  output  1  sticky: a frame was dropped.
- o_sync  output  1  high once frame alignment is acquired.

Behaviour:
- Reset (reset=0, asynchronous): o_left=0, o_right=0, o_valid=0, o_overrun=0, o_sync=0, state=HUNT, bit counter=0, shift register=0, left hold=0, synchronizer flops=0.
- Input path: i_sclk, i_lrclk and i_sdin each pass through a 2-flop synchronizer.
- A third sclk flop detects the SCLK rising edge and produces a one-clk strobe "bit_edge".
- ws and sd are sampled only on bit_edge. ws_prev is the ws sampled at the previous bit_edge.
- Bit shifting (at each bit_edge):
  - If count < WIDTH: shift sd into shift register bit (WIDTH-1-count).
  - Count saturates at 2^CNT_W-1. Bits beyond WIDTH are discarded.
  - Slots shorter than WIDTH are zero-padded in the LSBs (left-justified).
- Word end (I2S one-bit delay): a bit_edge with ws != ws_prev still carries the last bit of the old channel.
  - That bit is shifted in first.
  - The word then completes for channel ws_prev.
  - Shift register and count are cleared for the next word.
- State machine:
  - HUNT: ignore data. On word end with ws_prev=1 (ws 1->0), go to LEFT and assert o_sync. The first, partial right word is discarded.
  - LEFT: on word end with ws_prev=0, copy the word to left hold and go to RIGHT.
  - RIGHT: on word end with ws_prev=1, emit frame {left hold, word} and go to LEFT.
- Emit rules:
  - If o_valid=0, or (o_valid=1 and i_ready=1) in the same clk: load o_left/o_right and set o_valid=1 on the next clk.
  - If o_valid=1 and i_ready=0: keep the held frame unchanged, drop the new frame, and set o_overrun=1.
- Handshake: o_valid clears on the clk after o_valid and i_ready are both high, unless a new frame is loaded in that same clk. o_left/o_right stay stable while o_valid=1.
- o_overrun is cleared by i_clr_ovr=1. If a drop and i_clr_ovr occur in the same clk, the drop wins and o_overrun stays 1.
- Latency: o_valid rises 4 clks (+1 for synchronizer phase) after the SCLK rising edge at the pin that carries the final right-channel bit.
- o_sync drops and state returns to HUNT only on reset.
- Reset mid-frame: the partial frame is lost. After release, the first emitted frame is the first complete left+right pair after the next ws 1->0 transition.

Test Plan:
- Normal frame: WIDTH=16, 32 SCLK/frame at 3.125 MHz, left=0x1234, right=0xABCD, i_ready=1 -> after the HUNT frame, o_valid pulses once per frame with o_left=0x1234, o_right=0xABCD; o_overrun=0.
- Long slot: 24-bit slots, left=0x123456, right=0xFEDCBA -> o_left=0x1234, o_right=0xFEDC.
- Short slot: 8-bit slots, left=0xA5, right=0x3C -> o_left=0xA500, o_right=0x3C00.
- Backpressure: i_ready=0 across two frames (0x1111/0x2222, then 0x3333/0x4444) -> held frame stays 0x1111/0x2222 and o_overrun=1. Then i_ready=1 -> next frame accepted. Then i_clr_ovr pulse -> o_overrun=0.
- Startup alignment: release reset mid right-channel slot -> o_sync rises at the first ws 1->0, and the first o_valid carries the following complete pair; no partial data is emitted.
- Reset mid-frame: assert reset during left bit 7 -> all outputs 0 immediately (asynchronous). After release, behaviour matches the startup alignment case.
